// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchronizer plus stability-qualified level FSM with edge pulses
module input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    input  logic en,
    output logic d_out,
    output logic rise_p,
    output logic fall_p,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             sync_q, sync_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            d_out_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        // Synchronizer runs every cycle; only the FSM is gated by en.
        s1_d    = raw_in;
        sync_d  = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        d_out_d = d_out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE_LO: begin
                    if (sync_q) begin
                        state_d = WAIT_HI;
                        cnt_d   = '0;
                    end
                end
                WAIT_HI: begin
                    // A level change beats the terminal count on the same edge.
                    if (!sync_q) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_TERM) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                        d_out_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!sync_q) begin
                        state_d = WAIT_LO;
                        cnt_d   = '0;
                    end
                end
                WAIT_LO: begin
                    if (sync_q) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_TERM) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                        d_out_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    assign d_out  = d_out_q;
    assign rise_p = rise_q;
    assign fall_p = fall_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed scoreboard bench for input_debouncer
module tb_input_debouncer;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic raw_in = 1'b1;
    logic en     = 1'b1;
    logic d_out, rise_p, fall_p, busy;

    always #5 clk = ~clk;

    input_debouncer #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw_in),
        .en     (en),
        .d_out  (d_out),
        .rise_p (rise_p),
        .fall_p (fall_p),
        .busy   (busy)
    );

    // Expected value packing: {d_out, rise_p, fall_p, busy}
    typedef struct {
        logic [3:0] v;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic compare(input string tag, input logic [3:0] act, input logic [3:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got d/rise/fall/busy=%b required %b at %0t", tag, act, expv, $time);
        end
    endtask

    // Monitor: one DUT output sample per cycle, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compare(e.tag, {d_out, rise_p, fall_p, busy}, e.v);
            end
        end
    end

    task automatic step(input logic r, input logic raw, input logic e_n,
                        input logic [3:0] expv, input string tag);
        @(negedge clk);
        #1;
        rst    = r;
        raw_in = raw;
        en     = e_n;
        @(posedge clk);
        sb_q.push_back('{v: expv, tag: tag});
    endtask

    task automatic rep(input int n, input logic r, input logic raw, input logic e_n,
                       input logic [3:0] expv, input string tag);
        for (int i = 0; i < n; i++) step(r, raw, e_n, expv, tag);
    endtask

    task automatic clean_rise(input string tag);
        rep(2, 1'b1, 1'b1, 1'b1, 4'b0000, {tag, "_sync"});
        rep(4, 1'b1, 1'b1, 1'b1, 4'b0001, {tag, "_wait"});
        rep(1, 1'b1, 1'b1, 1'b1, 4'b1100, {tag, "_accept"});
        rep(2, 1'b1, 1'b1, 1'b1, 4'b1000, {tag, "_after"});
    endtask

    task automatic clean_fall(input string tag);
        rep(2, 1'b1, 1'b0, 1'b1, 4'b1000, {tag, "_sync"});
        rep(4, 1'b1, 1'b0, 1'b1, 4'b1001, {tag, "_wait"});
        rep(1, 1'b1, 1'b0, 1'b1, 4'b0010, {tag, "_accept"});
        rep(2, 1'b1, 1'b0, 1'b1, 4'b0000, {tag, "_after"});
    endtask

    initial begin
        #1;
        compare("reset_init", {d_out, rise_p, fall_p, busy}, 4'b0000);
        rep(2, 1'b0, 1'b1, 1'b1, 4'b0000, "reset_hold");
        rep(3, 1'b1, 1'b0, 1'b1, 4'b0000, "idle_lo");

        clean_rise("rise");
        clean_fall("fall");

        // 3-cycle high glitch: only three enabled samples of sync high
        step(1'b1, 1'b1, 1'b1, 4'b0000, "glitch_hi_a");
        step(1'b1, 1'b1, 1'b1, 4'b0000, "glitch_hi_b");
        step(1'b1, 1'b1, 1'b1, 4'b0001, "glitch_hi_c");
        step(1'b1, 1'b0, 1'b1, 4'b0001, "glitch_hi_d");
        step(1'b1, 1'b0, 1'b1, 4'b0001, "glitch_hi_e");
        rep(3, 1'b1, 1'b0, 1'b1, 4'b0000, "glitch_hi_reject");

        clean_rise("rise2");

        // 4-cycle low glitch: sync returns high exactly on the terminal-count edge
        rep(2, 1'b1, 1'b0, 1'b1, 4'b1000, "glitch_lo_sync");
        rep(2, 1'b1, 1'b0, 1'b1, 4'b1001, "glitch_lo_wait");
        rep(2, 1'b1, 1'b1, 1'b1, 4'b1001, "glitch_lo_tail");
        rep(3, 1'b1, 1'b1, 1'b1, 4'b1000, "glitch_lo_reject");

        clean_fall("fall2");

        // Enable every other cycle
        for (int k = 0; k < 14; k++) begin
            if (k < 2)       step(1'b1, 1'b1, (k % 2) == 0, 4'b0000, "engate_sync");
            else if (k < 10) step(1'b1, 1'b1, (k % 2) == 0, 4'b0001, "engate_wait");
            else if (k == 10) step(1'b1, 1'b1, 1'b1, 4'b1100, "engate_accept");
            else             step(1'b1, 1'b1, (k % 2) == 0, 4'b1000, "engate_after");
        end

        clean_fall("fall3");

        // Reset while WAIT_HI with cnt=2
        rep(2, 1'b1, 1'b1, 1'b1, 4'b0000, "midrst_sync");
        rep(3, 1'b1, 1'b1, 1'b1, 4'b0001, "midrst_wait");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        compare("midrst_async", {d_out, rise_p, fall_p, busy}, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b0000, "midrst_hold");
        rep(2, 1'b1, 1'b1, 1'b1, 4'b0000, "midrst_rel_sync");
        rep(4, 1'b1, 1'b1, 1'b1, 4'b0001, "midrst_rel_wait");
        rep(1, 1'b1, 1'b1, 1'b1, 4'b1100, "midrst_rel_accept");
        rep(2, 1'b1, 1'b1, 1'b1, 4'b1000, "midrst_rel_after");

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
